// File: rtl/tg68k_cache_pkg.sv
// Shared types and constants for the 68030 cache line fetcher.
//   state_e    : fetcher FSM states
//   LINE_WORDS : 16-bit words in one cache line
//   OFS_W      : width of the word index within a line
//   ERR_WORD   : data returned in place of a word whose read timed out
package tg68k_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ISSUE,
    WAIT,
    ACK,
    RELEASE
  } state_e;

  localparam int          LINE_WORDS = 8;
  localparam int          OFS_W      = $clog2(LINE_WORDS);
  localparam logic [15:0] ERR_WORD   = 16'hFFFF;

endpackage

// File: rtl/cache_line_fetcher.sv
// Cache line fetcher: takes a line-fill request from the CPU bus wrapper,
// reads the line from one SDRAM client port as ascending 16-bit words and
// hands each word back as a one-cycle cache_ack pulse.
//
// Ports
//   clk, nreset                  clock, async active-low reset
//   cache_req/addr/burst/len     fill request from the wrapper (level)
//   cache_data, cache_ack        returned word and its one-cycle strobe
//   mem_req/addr/burst           word read request towards SDRAM
//   mem_rdata, mem_valid         read data and its one-cycle strobe
//   busy                         high whenever the FSM is not in IDLE
//   err_timeout                  one-cycle pulse when a word timed out
//
// state   | meaning
// IDLE    | waiting for cache_req
// LEAD    | optional data-less arming ack
// ISSUE   | present the next word address, load the timer
// WAIT    | mem_req high until mem_valid or timer expiry
// ACK     | cache_ack/cache_data high for one cycle
// RELEASE | line done; hold until the wrapper moves off this line
module cache_line_fetcher
  import tg68k_cache_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int TIMEOUT  = 255,
  parameter bit LEAD_ACK = 1'b1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cache_req,
  input  logic [31:0]       cache_addr,
  input  logic              cache_burst,
  input  logic [2:0]        cache_burst_len,
  output logic [15:0]       cache_data,
  output logic              cache_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_burst,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [27:0]       line_q, line_d;
  logic [OFS_W-1:0]  last_q, last_d;
  logic [OFS_W-1:0]  w_q, w_d;
  logic              burst_q, burst_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [15:0]       cache_data_q, cache_data_d;
  logic              cache_ack_q, cache_ack_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_burst_q, mem_burst_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;

  // Line is always fetched from offset 0, so the low address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cache_addr[3:0];

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    last_d        = last_q;
    w_d           = w_q;
    burst_d       = burst_q;
    tmr_d         = tmr_q;
    cache_data_d  = cache_data_q;
    cache_ack_d   = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_burst_d   = mem_burst_q;
    err_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cache_req) begin
          line_d  = cache_addr[31:4];
          last_d  = cache_burst_len;
          burst_d = cache_burst;
          w_d     = '0;
          if (LEAD_ACK) begin
            state_d      = LEAD;
            cache_ack_d  = 1'b1;
            cache_data_d = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      LEAD: state_d = ISSUE;
      ISSUE: begin
        mem_req_d   = 1'b1;
        mem_addr_d  = ADDR_W'({line_q, w_q, 1'b0});
        mem_burst_d = burst_q;
        tmr_d       = TMR_LOAD;
        state_d     = WAIT;
      end
      WAIT: begin
        // Real data is checked first so it wins a same-cycle expiry.
        if (mem_valid) begin
          mem_req_d    = 1'b0;
          cache_ack_d  = 1'b1;
          cache_data_d = mem_rdata;
          state_d      = ACK;
        end else if (tmr_q == '0) begin
          mem_req_d     = 1'b0;
          cache_ack_d   = 1'b1;
          cache_data_d  = ERR_WORD;
          err_timeout_d = 1'b1;
          state_d       = ACK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ACK: begin
        if (w_q == last_q) begin
          mem_burst_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          w_d     = w_q + 1'b1;
          state_d = ISSUE;
        end
      end
      RELEASE: begin
        // Stay until the wrapper stops asking for this line, so its
        // completion pulse cannot trigger a refetch of the same line.
        if (!cache_req || (cache_addr[31:4] != line_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      line_q        <= '0;
      last_q        <= '0;
      w_q           <= '0;
      burst_q       <= 1'b0;
      tmr_q         <= '0;
      cache_data_q  <= '0;
      cache_ack_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_burst_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      last_q        <= last_d;
      w_q           <= w_d;
      burst_q       <= burst_d;
      tmr_q         <= tmr_d;
      cache_data_q  <= cache_data_d;
      cache_ack_q   <= cache_ack_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_burst_q   <= mem_burst_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cache_data  = cache_data_q;
  assign cache_ack   = cache_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_burst   = mem_burst_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_cache_line_fetcher.sv
// Self-checking bench for cache_line_fetcher. Main instance: LEAD_ACK=1,
// TIMEOUT=15; second instance: LEAD_ACK=0 for the short-line case.
module tb_cache_line_fetcher;

  localparam int AW = 24;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          cache_req = 1'b0;
  logic [31:0]   cache_addr = '0;
  logic          cache_burst = 1'b0;
  logic [2:0]    cache_burst_len = '0;
  logic [15:0]   cache_data;
  logic          cache_ack;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_burst;
  logic [15:0]   mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          busy;
  logic          err_timeout;

  logic          req0 = 1'b0;
  logic [31:0]   addr0 = '0;
  logic          burst0 = 1'b0;
  logic [2:0]    len0 = '0;
  logic [15:0]   data0;
  logic          ack0;
  logic          mreq0;
  logic [AW-1:0] maddr0;
  logic          mburst0;
  logic [15:0]   rdata0 = '0;
  logic          valid0 = 1'b0;
  logic          busy0;
  logic          err0;

  cache_line_fetcher #(.ADDR_W(AW), .TIMEOUT(TO), .LEAD_ACK(1'b1)) dut (
    .clk(clk), .nreset(nreset), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_burst(cache_burst), .cache_burst_len(cache_burst_len),
    .cache_data(cache_data), .cache_ack(cache_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_burst(mem_burst), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .busy(busy), .err_timeout(err_timeout));

  cache_line_fetcher #(.ADDR_W(AW), .TIMEOUT(TO), .LEAD_ACK(1'b0)) dut0 (
    .clk(clk), .nreset(nreset), .cache_req(req0), .cache_addr(addr0),
    .cache_burst(burst0), .cache_burst_len(len0),
    .cache_data(data0), .cache_ack(ack0), .mem_req(mreq0),
    .mem_addr(maddr0), .mem_burst(mburst0), .mem_rdata(rdata0),
    .mem_valid(valid0), .busy(busy0), .err_timeout(err0));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Memory model: word at byte address a holds a[16:1] ^ data_key.
  logic [15:0] data_key = '0;
  function automatic logic [15:0] mem_fn(input logic [AW-1:0] a);
    return a[16:1] ^ data_key;
  endfunction

  // Responder for the main instance.
  int            mem_delay = 0;
  int            max_delay = 0;
  int            wait_cnt = 0;
  bit            rand_delay = 1'b0;
  bit            stall_en = 1'b0;
  logic [AW-1:0] stall_a = '0;

  always @(negedge clk) begin
    if (mem_valid) begin
      mem_valid = 1'b0;
      wait_cnt = 0;
      if (rand_delay) mem_delay = int'($urandom_range(max_delay, 0));
    end else if (mem_req && !(stall_en && mem_addr == stall_a)) begin
      if (wait_cnt >= mem_delay) begin
        mem_valid = 1'b1;
        mem_rdata = mem_fn(mem_addr);
      end else begin
        wait_cnt++;
      end
    end else if (!mem_req) begin
      wait_cnt = 0;
    end
  end

  // Responder for the LEAD_ACK=0 instance: answers immediately.
  always @(negedge clk) begin
    if (valid0) valid0 = 1'b0;
    else if (mreq0) begin
      valid0 = 1'b1;
      rdata0 = maddr0[16:1] ^ 16'h5A5A;
    end
  end

  // Observation: per-cycle history indexed by negedge count since clear.
  bit            burst_hist[$];
  logic [15:0]   ack_data[$];
  int            ack_idx[$];
  bit            ack_err[$];
  logic [AW-1:0] addr_q[$];
  int            req_idx[$];
  int            err_cnt = 0;
  bit            req_prev = 1'b0;
  logic [15:0]   ack0_data[$];
  int            req0_rises = 0;
  bit            req0_prev = 1'b0;

  always @(negedge clk) begin
    burst_hist.push_back(mem_burst);
    if (mem_req && !req_prev) begin
      addr_q.push_back(mem_addr);
      req_idx.push_back(burst_hist.size() - 1);
    end
    req_prev = mem_req;
    if (cache_ack) begin
      ack_data.push_back(cache_data);
      ack_idx.push_back(burst_hist.size() - 1);
      ack_err.push_back(err_timeout);
    end
    if (err_timeout) err_cnt++;
    if (ack0) ack0_data.push_back(data0);
    if (mreq0 && !req0_prev) req0_rises++;
    req0_prev = mreq0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    burst_hist.delete(); ack_data.delete(); ack_idx.delete(); ack_err.delete();
    addr_q.delete(); req_idx.delete(); err_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":cache_ack"}, 32'(cache_ack), 32'd0);
    chk({tag, ":cache_data"}, 32'(cache_data), 32'd0);
    chk({tag, ":mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, ":mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, ":mem_burst"}, 32'(mem_burst), 32'd0);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    chk({tag, ":err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // One line fill on the main instance, checked against the model.
  // start_lat: cycles from request to the arming ack (1 from IDLE, 2 from RELEASE).
  task automatic run_fill(input logic [31:0] a, input logic [2:0] len, input bit burst,
                          input bit stall, input logic [2:0] stall_w, input bit drop_req,
                          input bit keep_req, input int start_lat, input string tag);
    logic [AW-1:0] base, wa;
    logic [15:0]   exp_d;
    int            nexp, budget, bad, exp_err, lat;
    bit            st;
    base = AW'({a[31:4], 4'h0});
    clear_mon();
    stall_en = stall;
    stall_a = AW'(base + AW'(2 * int'(stall_w)));
    cache_addr = a; cache_burst_len = len; cache_burst = burst; cache_req = 1'b1;
    repeat (start_lat) tick();
    chk({tag, ":lead_ack"}, 32'(cache_ack), 32'd1);
    cache_burst_len = 3'($urandom);
    if (drop_req) cache_req = 1'b0;
    nexp = int'(len) + 2;
    budget = 0;
    while (ack_data.size() < nexp && budget < 600) begin
      tick();
      budget++;
    end
    repeat (4) tick();
    chk({tag, ":ack_count"}, 32'(ack_data.size()), 32'(nexp));
    chk({tag, ":req_count"}, 32'(addr_q.size()), 32'(int'(len) + 1));
    if (ack_data.size() > 0) chk({tag, ":lead_data"}, 32'(ack_data[0]), 32'd0);
    exp_err = 0;
    for (int w = 0; w <= int'(len); w++) begin
      st = stall && (w == int'(stall_w));
      if (st) exp_err++;
      wa = AW'(base + AW'(2 * w));
      exp_d = st ? 16'hFFFF : mem_fn(wa);
      if (w < addr_q.size()) chk($sformatf("%s:addr%0d", tag, w), 32'(addr_q[w]), 32'(wa));
      if (w + 1 < ack_data.size()) begin
        chk($sformatf("%s:data%0d", tag, w), 32'(ack_data[w + 1]), 32'(exp_d));
        chk($sformatf("%s:err%0d", tag, w), 32'(ack_err[w + 1]), 32'(st));
      end
      if (!rand_delay && w < req_idx.size() && w + 1 < ack_idx.size()) begin
        lat = ack_idx[w + 1] - req_idx[w];
        chk($sformatf("%s:lat%0d", tag, w), 32'(lat), st ? 32'(TO + 1) : 32'(mem_delay + 1));
      end
      if (!rand_delay && mem_delay == 0 && !stall && w > 0 && w + 1 < ack_idx.size())
        chk($sformatf("%s:spacing%0d", tag, w), 32'(ack_idx[w + 1] - ack_idx[w]), 32'd3);
    end
    chk({tag, ":err_pulses"}, 32'(err_cnt), 32'(exp_err));
    if (req_idx.size() > 0 && ack_idx.size() > 0) begin
      bad = 0;
      for (int i = req_idx[0]; i <= ack_idx[ack_idx.size() - 1]; i++)
        if (burst_hist[i] != burst) bad++;
      chk({tag, ":burst_window"}, 32'(bad), 32'd0);
    end
    if (drop_req) begin
      chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, ":release_busy"}, 32'(busy), 32'd1);
      chk({tag, ":release_burst"}, 32'(mem_burst), 32'd0);
      if (!keep_req) begin
        cache_req = 1'b0;
        repeat (2) tick();
        chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n, budget;
    logic [AW-1:0] b0, t;
    logic [31:0]   ra;

    repeat (3) tick();
    chk_zero("reset");
    nreset = 1'b1;
    tick();

    // Basic fill then release hold on the same line, then move to the next line.
    data_key = '0; mem_delay = 2; rand_delay = 1'b0;
    run_fill(32'h0001_2346, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1, "basic");
    n = addr_q.size();
    repeat (5) tick();
    chk("hold:no_new_req", 32'(addr_q.size()), 32'(n));
    chk("hold:busy", 32'(busy), 32'd1);
    chk("hold:mem_req", 32'(mem_req), 32'd0);
    run_fill(32'h0001_2350, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2, "newline");

    // Burst hint with zero-latency memory.
    data_key = 16'($urandom); mem_delay = 0;
    run_fill($urandom, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1, "burst");

    // Word 3 never answered.
    mem_delay = 1;
    run_fill($urandom, 3'd7, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1, "timeout");

    // mem_valid on the very cycle the timer expires: data wins.
    mem_delay = TO;
    run_fill($urandom, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1, "race");

    // Reset during word 4 WAIT.
    clear_mon();
    mem_delay = 10; stall_en = 1'b0;
    cache_addr = $urandom; cache_burst_len = 3'd7; cache_burst = 1'b1; cache_req = 1'b1;
    budget = 0;
    while (addr_q.size() < 5 && budget < 400) begin
      tick();
      budget++;
    end
    chk("midrst:reached_word4", 32'(addr_q.size() >= 5), 32'd1);
    tick();
    nreset = 1'b0;
    #1;
    chk_zero("midrst");
    cache_req = 1'b0;
    tick();
    nreset = 1'b1;
    n = ack_data.size();
    repeat (10) tick();
    chk("midrst:no_ack", 32'(ack_data.size()), 32'(n));
    chk("midrst:idle", 32'(busy), 32'd0);
    mem_delay = 0;
    run_fill($urandom, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1, "after_rst");

    // Short line on the LEAD_ACK=0 instance.
    ack0_data.delete(); req0_rises = 0;
    addr0 = $urandom; len0 = 3'd1; req0 = 1'b1;
    b0 = AW'({addr0[31:4], 4'h0});
    budget = 0;
    while (ack0_data.size() < 2 && budget < 100) begin
      tick();
      budget++;
    end
    repeat (5) tick();
    chk("short:ack_count", 32'(ack0_data.size()), 32'd2);
    chk("short:req_count", 32'(req0_rises), 32'd2);
    for (int w = 0; w < 2; w++) begin
      t = AW'(b0 + AW'(2 * w));
      if (w < ack0_data.size())
        chk($sformatf("short:data%0d", w), 32'(ack0_data[w]), 32'(t[16:1] ^ 16'h5A5A));
    end
    chk("short:release", 32'(busy0), 32'd1);
    req0 = 1'b0;
    repeat (2) tick();
    chk("short:idle", 32'(busy0), 32'd0);

    // Randomized fills.
    rand_delay = 1'b1; max_delay = 4;
    for (int k = 0; k < 8; k++) begin
      data_key = 16'($urandom);
      mem_delay = int'($urandom_range(4, 0));
      ra = $urandom;
      run_fill(ra, 3'($urandom), 1'($urandom), ($urandom_range(2, 0) == 0),
               3'($urandom), 1'($urandom), 1'b0, 1, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
